// File: rtl/axis_snoop_pkg.sv
// Shared definitions for the snoop debug framer.
//   framer_state_t      : frame sequencing states (SOF, seq, payload, length, checksum)
//   SNOOP_SOF_DEFAULT   : default start-of-frame marker byte
//   SNOOP_TRAILER_BYTES : bytes appended after the payload (len_lo, len_hi, csum)
package axis_snoop_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEQ    = 3'd1,
    DATA   = 3'd2,
    LEN_LO = 3'd3,
    LEN_HI = 3'd4,
    CSUM   = 3'd5
  } framer_state_t;

  localparam logic [7:0] SNOOP_SOF_DEFAULT   = 8'hA5;
  localparam int         SNOOP_TRAILER_BYTES = 3;

endpackage

// File: rtl/axis_byte_out_reg.sv
// Byte-wide AXIS output register with full backpressure.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load_en           : producer offers a byte this cycle (only taken when ld=1)
//   load_data/last    : byte and TLAST flag offered
//   m_tready          : downstream ready
//   ld                : register may accept a new byte this cycle
//   m_tvalid/tdata/tlast : registered AXIS master outputs
//
// Handshake: a byte transfers on a rising edge where m_tvalid & m_tready.
// While m_tvalid & ~m_tready the register holds data/last stable; valid
// never drops without a transfer.
module axis_byte_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic [7:0] load_data,
  input  logic       load_last,
  input  logic       m_tready,
  output logic       ld,
  output logic       m_tvalid,
  output logic [7:0] m_tdata,
  output logic       m_tlast
);

  logic       tvalid_q, tvalid_d;
  logic [7:0] tdata_q,  tdata_d;
  logic       tlast_q,  tlast_d;

  // Register is free when empty or when its current byte leaves this cycle.
  assign ld = ~tvalid_q | m_tready;

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (ld) begin
      tvalid_d = load_en;
      if (load_en) begin
        tdata_d = load_data;
        tlast_d = load_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tdata_q  <= 8'h00;
      tlast_q  <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign m_tlast  = tlast_q;

endmodule

// File: rtl/axis_snoop_framer.sv
// Wraps each snoop packet into a debug frame:
//   SOF, seq, payload..., len_lo, len_hi, csum (TLAST on csum)
// csum is the XOR of seq, every payload byte, len_lo and len_hi (SOF excluded).
// Ports:
//   AXIS_ACLK / AXIS_ARESETN : clock, asynchronous active-low reset
//   S_AXIS_*                 : 8-bit payload slave from the snoop FIFO
//   M_AXIS_*                 : 8-bit frame master towards the serialiser
//   FRAME_COUNT              : frames whose checksum byte has been handshaken
//   dbg_state                : current framer state
//
// Handshake: on both sides a beat transfers on a rising edge where
// TVALID & TREADY. S_AXIS_TREADY is (state==DATA) & ld and never looks at
// S_AXIS_TVALID; the master side holds its byte stable while stalled.
module axis_snoop_framer
  import axis_snoop_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE  = SNOOP_SOF_DEFAULT,
  parameter int         LEN_WIDTH = 16
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESETN,
  input  logic          S_AXIS_TVALID,
  output logic          S_AXIS_TREADY,
  input  logic [7:0]    S_AXIS_TDATA,
  input  logic          S_AXIS_TLAST,
  output logic          M_AXIS_TVALID,
  input  logic          M_AXIS_TREADY,
  output logic [7:0]    M_AXIS_TDATA,
  output logic          M_AXIS_TLAST,
  output logic [31:0]   FRAME_COUNT,
  output framer_state_t dbg_state
);

  framer_state_t        state_q, state_d;
  logic [7:0]           seq_q, seq_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [7:0]           csum_q, csum_d;
  logic [31:0]          frame_count_q, frame_count_d;

  logic       ld;
  logic       load_en;
  logic [7:0] load_data;
  logic       load_last;

  axis_byte_out_reg u_out (
    .clk       (AXIS_ACLK),
    .rst_n     (AXIS_ARESETN),
    .load_en   (load_en),
    .load_data (load_data),
    .load_last (load_last),
    .m_tready  (M_AXIS_TREADY),
    .ld        (ld),
    .m_tvalid  (M_AXIS_TVALID),
    .m_tdata   (M_AXIS_TDATA),
    .m_tlast   (M_AXIS_TLAST)
  );

  assign S_AXIS_TREADY = (state_q == DATA) & ld;

  always_comb begin
    state_d       = state_q;
    seq_d         = seq_q;
    len_d         = len_q;
    csum_d        = csum_q;
    frame_count_d = frame_count_q;
    load_en       = 1'b0;
    load_data     = 8'h00;
    load_last     = 1'b0;

    if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST)
      frame_count_d = frame_count_q + 32'd1;

    // Everything below only moves when the output register can take a byte,
    // which is what freezes the whole frame under downstream backpressure.
    if (ld) begin
      unique case (state_q)
        IDLE: begin
          // A waiting beat only starts the frame; it is consumed in DATA.
          if (S_AXIS_TVALID) begin
            load_en   = 1'b1;
            load_data = SOF_BYTE;
            len_d     = '0;
            csum_d    = 8'h00;
            state_d   = SEQ;
          end
        end
        SEQ: begin
          load_en   = 1'b1;
          load_data = seq_q;
          csum_d    = csum_q ^ seq_q;
          state_d   = DATA;
        end
        DATA: begin
          if (S_AXIS_TVALID) begin
            load_en   = 1'b1;
            load_data = S_AXIS_TDATA;
            csum_d    = csum_q ^ S_AXIS_TDATA;
            // Saturate: oversized packets still pass through, length pins at max.
            if (len_q != '1) len_d = len_q + 1'b1;
            if (S_AXIS_TLAST) state_d = LEN_LO;
          end
        end
        LEN_LO: begin
          load_en   = 1'b1;
          load_data = len_q[7:0];
          csum_d    = csum_q ^ len_q[7:0];
          state_d   = LEN_HI;
        end
        LEN_HI: begin
          load_en   = 1'b1;
          load_data = len_q[15:8];
          csum_d    = csum_q ^ len_q[15:8];
          state_d   = CSUM;
        end
        CSUM: begin
          load_en   = 1'b1;
          load_data = csum_q;
          load_last = 1'b1;
          seq_d     = seq_q + 8'd1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q       <= IDLE;
      seq_q         <= 8'h00;
      len_q         <= '0;
      csum_q        <= 8'h00;
      frame_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      seq_q         <= seq_d;
      len_q         <= len_d;
      csum_q        <= csum_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign FRAME_COUNT = frame_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_axis_snoop_framer.sv
module tb_axis_snoop_framer;
  import axis_snoop_pkg::*;

  localparam int W = 9;  // {tlast, tdata}

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst_n;
  logic          s_tvalid;
  logic          s_tready;
  logic [7:0]    s_tdata;
  logic          s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [7:0]    m_tdata;
  logic          m_tlast;
  logic [31:0]   frame_count;
  framer_state_t dbg_state;

  axis_snoop_framer dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TLAST  (m_tlast),
    .FRAME_COUNT   (frame_count),
    .dbg_state     (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [7:0]   pay_q[$];
  logic [7:0]   exp_seq;
  int           checks = 0;
  int           errors = 0;
  int           s_acc = 0;
  int           first_hs = -1;
  int           last_hs = -1;
  bit           rand_ready = 1'b0;
  bit           chk_stable = 1'b0;
  bit           stalled_prev = 1'b0;
  logic [W-1:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising
  // edge will act upon.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tdata});
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (s_tvalid && s_tready) s_acc++;
      if (chk_stable && stalled_prev) begin
        checks++;
        if (!(m_tvalid === 1'b1 && {m_tlast, m_tdata} === held)) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h expected v=1 %h", m_tvalid, {m_tlast, m_tdata}, held);
        end
      end
      stalled_prev = m_tvalid && !m_tready;
      held         = {m_tlast, m_tdata};
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Downstream ready: always 1, or random when rand_ready is set.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- reference model ----------------
  task automatic build_frame();
    int n;
    logic [15:0] len;
    logic [7:0]  cs;
    n   = pay_q.size();
    len = (n > 65535) ? 16'hFFFF : 16'(n);
    cs  = exp_seq;
    exp_q.push_back({1'b0, SNOOP_SOF_DEFAULT});
    exp_q.push_back({1'b0, exp_seq});
    foreach (pay_q[i]) begin
      exp_q.push_back({1'b0, pay_q[i]});
      cs ^= pay_q[i];
    end
    cs ^= len[7:0] ^ len[15:8];
    exp_q.push_back({1'b0, len[7:0]});
    exp_q.push_back({1'b0, len[15:8]});
    exp_q.push_back({1'b1, cs});
    exp_seq = exp_seq + 8'd1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_pkt();
    int n;
    n = pay_q.size();
    for (int i = 0; i < n; i++) begin
      int t;
      s_tvalid = 1'b1;
      s_tdata  = pay_q[i];
      s_tlast  = (i == n - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (s_tready) break;
        t++;
        if (t > 2000) begin
          $display("FAIL s_beat_timeout: got no S handshake for beat %0d expected one within 2000 cycles", i);
          errors++;
          checks++;
          break;
        end
        @(posedge clk);
        #1;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_out(input int n, input int bound);
    int t;
    t = 0;
    while (got_q.size() < n && t < bound) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic compare_stream(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_len: got %0d bytes expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s: byte %0d got %h expected %h", name, i, got_q[i], exp_q[i]);
          break;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_seq = 8'h00;
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [3:0]       n_in;
    logic [0:3][7:0]  din;
    logic [3:0]       n_out;
    logic [0:8][7:0]  dout;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'd3, 32'h11223300, 4'd8, 72'hA5_00_11_22_33_03_00_03_00};
    vecs[1] = '{4'd1, 32'hAA000000, 4'd6, 72'hA5_01_AA_01_00_AA_00_00_00};
    vecs[2] = '{4'd2, 32'h01020000, 4'd7, 72'hA5_02_01_02_02_00_03_00_00};
    vecs[3] = '{4'd1, 32'hFF000000, 4'd6, 72'hA5_03_FF_01_00_FD_00_00_00};
    vecs[4] = '{4'd4, 32'h80000000, 4'd9, 72'hA5_04_80_00_00_00_04_00_80};

    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    exp_seq  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    check("rst_m_tlast", 32'(m_tlast), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_frame_count", frame_count, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: hand-computed frames, ready held high.
    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      pay_q.delete();
      for (int j = 0; j < int'(vecs[v].n_in); j++) pay_q.push_back(vecs[v].din[j]);
      send_pkt();
      wait_out(int'(vecs[v].n_out), 200);
      for (int j = 0; j < int'(vecs[v].n_out); j++)
        check($sformatf("vec%0d_byte%0d", v, j), 32'(got_q[j]),
              32'({(j == int'(vecs[v].n_out) - 1), vecs[v].dout[j]}));
      check($sformatf("vec%0d_frame_count", v), frame_count, 32'(v + 1));
      exp_seq = exp_seq + 8'd1;
    end

    // Random downstream stalls over a 64-byte packet.
    got_q.delete();
    exp_q.delete();
    pay_q.delete();
    for (int i = 0; i < 64; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    build_frame();
    s_acc      = 0;
    rand_ready = 1'b1;
    chk_stable = 1'b1;
    send_pkt();
    wait_out(64 + 2 + SNOOP_TRAILER_BYTES, 2000);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_stable = 1'b0;
    compare_stream("stall_stream");
    check("stall_s_beats", 32'(s_acc), 32'd64);
    check("stall_frame_count", frame_count, 32'd6);

    // Asynchronous reset in the middle of DATA.
    got_q.delete();
    s_tvalid = 1'b1;
    s_tdata  = 8'h11;
    s_tlast  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_state_data", 32'(dbg_state), 32'(DATA));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("arst_m_tdata", 32'(m_tdata), 32'd0);
    check("arst_m_tlast", 32'(m_tlast), 32'd0);
    check("arst_s_tready", 32'(s_tready), 32'd0);
    check("arst_frame_count", frame_count, 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_seq = 8'h00;
    got_q.delete();
    exp_q.delete();
    pay_q.delete();
    pay_q.push_back(8'h5A);
    build_frame();
    send_pkt();
    wait_out(6, 200);
    compare_stream("post_reset_stream");
    check("post_reset_seq", 32'(got_q[1]), 32'h000);
    check("post_reset_csum", 32'(got_q[5]), 32'h15B);

    // 256 packets: sequence number runs 00..FF then wraps.
    do_reset();
    for (int p = 0; p < 256; p++) begin
      pay_q.delete();
      pay_q.push_back(8'($urandom_range(0, 255)));
      build_frame();
      send_pkt();
    end
    wait_out(256 * 6, 500);
    compare_stream("wrap_stream");
    check("wrap_frame_count", frame_count, 32'd256);
    check("wrap_seq_ff", 32'(got_q[255 * 6 + 1]), 32'h0FF);
    got_q.delete();
    exp_q.delete();
    pay_q.delete();
    pay_q.push_back(8'h3C);
    build_frame();
    send_pkt();
    wait_out(6, 200);
    check("wrap_seq_00", 32'(got_q[1]), 32'h000);
    check("wrap_frame_count_257", frame_count, 32'd257);

    // 70000-byte packet: length saturates, stream stays bubble-free.
    got_q.delete();
    exp_q.delete();
    pay_q.delete();
    for (int i = 0; i < 70000; i++) pay_q.push_back(8'(i ^ (i >> 8)));
    build_frame();
    first_hs = -1;
    send_pkt();
    wait_out(70005, 1000);
    compare_stream("big_stream");
    check("big_len_lo", 32'(got_q[70002]), 32'h0FF);
    check("big_len_hi", 32'(got_q[70003]), 32'h0FF);
    check("big_csum", 32'(got_q[70004]), 32'(exp_q[70004]));
    check("big_no_bubbles", 32'(last_hs - first_hs), 32'd70004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
